// File: rtl/regfile_scoreboard_arbiter.sv
// Register-file scoreboard with a two-requester writeback arbiter.
//
// Tracks outstanding writes per architectural register with a 2-bit pending
// counter. It holds decode on RAW hazards or counter saturation. It also
// arbitrates ALU and load writebacks round-robin onto a single registered
// register-file write port.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   dec_valid, dec_rs1, dec_rs2, dec_rs2_valid, dec_rd, dec_rd_valid
//                              decode-stage sources and destination
//   issue_ready, raw_stall      decode may issue / decode held
//   alu_wb_valid/addr/data, alu_wb_ready    ALU writeback requester
//   mem_wb_valid/addr/data, mem_wb_ready    load writeback requester
//   rf_write_enable/addr/data  registered register-file write port
//   flush                      clears all pending counters
//   busy_mask                  bit i set while register i has pending writes
//   wb_underflow_err           sticky: writeback to a register with none pending
module regfile_scoreboard_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [ADDR_WIDTH-1:0] dec_rs1,
  input  logic [ADDR_WIDTH-1:0] dec_rs2,
  input  logic                  dec_rs2_valid,
  input  logic [ADDR_WIDTH-1:0] dec_rd,
  input  logic                  dec_rd_valid,
  output logic                  issue_ready,
  output logic                  raw_stall,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  flush,
  output logic [31:0]           busy_mask,
  output logic                  wb_underflow_err
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  typedef enum logic {
    PRIO_ALU,
    PRIO_MEM
  } prio_e;

  prio_e             prio;
  logic [1:0]        cnt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [1:0]        cnt_rs1;
  logic [1:0]        cnt_rs2;
  logic [1:0]        cnt_rd;
  logic              alu_hs;
  logic              mem_hs;
  logic              underflow;

  // While reset is asserted the hazard check sees the counters as already cleared.
  always_comb begin
    cnt_rs1 = reset ? '0 : cnt[dec_rs1];
    cnt_rs2 = reset ? '0 : cnt[dec_rs2];
    cnt_rd  = reset ? '0 : cnt[dec_rd];
  end

  always_comb begin
    raw_stall = dec_valid &&
                ((cnt_rs1 != '0) ||
                 (dec_rs2_valid && (cnt_rs2 != '0)) ||
                 (dec_rd_valid && (dec_rd != '0) && (cnt_rd == 2'd3)) ||
                 flush);
  end

  assign issue_ready = dec_valid && !raw_stall;

  always_comb begin
    alu_wb_ready = 1'b0;
    mem_wb_ready = 1'b0;
    if (!reset) begin
      if (alu_wb_valid && (!mem_wb_valid || (prio == PRIO_ALU))) begin
        alu_wb_ready = 1'b1;
      end else if (mem_wb_valid) begin
        mem_wb_ready = 1'b1;
      end
    end
  end

  assign alu_hs = alu_wb_valid && alu_wb_ready;
  assign mem_hs = mem_wb_valid && mem_wb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio            <= PRIO_ALU;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= 1'b0;
      if (alu_hs) begin
        prio            <= PRIO_MEM;
        rf_write_addr   <= alu_wb_addr;
        rf_write_data   <= alu_wb_data;
        rf_write_enable <= (alu_wb_addr != '0);
      end else if (mem_hs) begin
        prio            <= PRIO_ALU;
        rf_write_addr   <= mem_wb_addr;
        rf_write_data   <= mem_wb_data;
        rf_write_enable <= (mem_wb_addr != '0);
      end
    end
  end

  // Retire on the cycle the write port is driven, so decode cannot observe
  // the cleared counter before the register file holds the data.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_ready && dec_rd_valid) begin
      inc_vec[dec_rd] = 1'b1;
    end
    if (rf_write_enable) begin
      dec_vec[rf_write_addr] = 1'b1;
    end
    underflow = rf_write_enable && (cnt[rf_write_addr] == '0) &&
                !inc_vec[rf_write_addr];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[ADDR_WIDTH'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (i == 0) begin
          cnt[ADDR_WIDTH'(i)] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          cnt[ADDR_WIDTH'(i)] <= cnt[ADDR_WIDTH'(i)] + 2'd1;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[ADDR_WIDTH'(i)] != '0)) begin
          cnt[ADDR_WIDTH'(i)] <= cnt[ADDR_WIDTH'(i)] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_underflow_err <= 1'b0;
    end else if (!flush && underflow) begin
      wb_underflow_err <= 1'b1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (i < NREG) begin
        busy_mask[i] = (cnt[ADDR_WIDTH'(i)] != '0);
      end
    end
  end

endmodule

// File: doc/regfile_scoreboard_arbiter.md
REGFILE_SCOREBOARD_ARBITER -- requirements
Module: regfile_scoreboard_arbiter

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL take parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports dec_valid  input  1, dec_rs1  input  ADDR_WIDTH, dec_rs2  input  ADDR_WIDTH, dec_rs2_valid  input  1: decode-stage source request.
REQ-006 SHALL have ports dec_rd  input  ADDR_WIDTH, dec_rd_valid  input  1: decode-stage destination.
REQ-007 SHALL have ports issue_ready  output  1 (instruction may issue) and raw_stall  output  1 (RAW or WAW-overflow hold).
REQ-008 SHALL have ports alu_wb_valid  input  1, alu_wb_addr  input  ADDR_WIDTH, alu_wb_data  input  DATA_WIDTH, alu_wb_ready  output  1: ALU writeback requester.
REQ-009 SHALL have ports mem_wb_valid  input  1, mem_wb_addr  input  ADDR_WIDTH, mem_wb_data  input  DATA_WIDTH, mem_wb_ready  output  1: load writeback requester.
REQ-010 SHALL have ports rf_write_enable  output  1, rf_write_addr  output  ADDR_WIDTH, rf_write_data  output  DATA_WIDTH: registered drive of the register-file write port.
REQ-011 SHALL have ports flush  input  1 (clear scoreboard), busy_mask  output  32 (bit i = register i pending), wb_underflow_err  output  1 (sticky).

Function
REQ-012 SHALL keep a 2-bit pending counter per register 1..31; register 0 never pending, busy_mask[0]=0 always.
REQ-013 raw_stall SHALL be combinational: 1 when dec_valid and (counter[rs1]!=0, or dec_rs2_valid and counter[rs2]!=0, or dec_rd_valid and rd!=0 and counter[rd]==3, or flush).
REQ-014 issue_ready SHALL equal dec_valid and not raw_stall.
REQ-015 On an edge with issue_ready=1, dec_rd_valid=1, dec_rd!=0: counter[rd] SHALL increment by 1.
REQ-016 Arbitration: only one requester valid -> that requester granted; both valid -> round-robin, requester not granted last time wins; after reset ALU wins first conflict.
REQ-017 Grant SHALL be expressed as combinational ready (alu_wb_ready/mem_wb_ready); at most one ready high per cycle; handshake completes on edge where valid and ready both 1.
REQ-018 Requester SHALL hold valid/addr/data stable until handshake; ready never depends on flush.
REQ-019 Handshake in cycle N SHALL register addr/data and drive rf_write_enable=1 throughout cycle N+1 (latency 1); no handshake -> rf_write_enable=0 in N+1, addr/data hold last value.
REQ-020 Handshake with addr 0 SHALL complete but leave rf_write_enable=0 next cycle.
REQ-021 counter[rf_write_addr] SHALL decrement on the edge ending a cycle with rf_write_enable=1 (same edge the register file captures data), so decode sees the new value no earlier than the data.
REQ-022 Increment and decrement of the same register on the same edge SHALL leave counter unchanged.
REQ-023 Decrement of a counter already 0 SHALL leave it 0 and set wb_underflow_err=1 until reset.
REQ-024 flush=1 SHALL zero all counters at that edge, overriding same-edge increment and decrement; rf_write_enable/addr/data pipeline unaffected (in-flight write still lands).
REQ-025 Increment at counter 3 SHALL be impossible (blocked by REQ-013); counters never wrap.

Reset
REQ-026 reset=1 at an edge SHALL clear all counters, busy_mask=0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, wb_underflow_err=0, round-robin pointer to ALU-first.
REQ-027 Reset SHALL override issue, handshake, flush and decrement on the same edge; a write registered before reset SHALL NOT appear after it.
REQ-028 During reset alu_wb_ready/mem_wb_ready SHALL be 0 and raw_stall follows REQ-013 using cleared counters.

Verification
REQ-029 Issue rd=5 cycle 0 -> busy_mask[5]=1 cycle 1; decode rs1=5 stalls; ALU wb addr5 data 0xAA handshake cycle 3 -> rf_write_enable=1, addr 5, data 0xAA cycle 4; busy_mask[5]=0 and raw_stall=0 cycle 5.
REQ-030 Both requesters valid 4 consecutive cycles (addr 6, addr 7) -> grants ALU, MEM, ALU, MEM; never both ready.
REQ-031 Issue rd=9 three times -> counter 3; fourth issue with rd=9 -> raw_stall=1; one write to 9 -> counter 2, issue proceeds.
REQ-032 Issue rd=3 and writeback to 3 (counter 1) on same edge -> counter stays 1; flush next cycle -> busy_mask=0 while rf_write_enable=1 for reg 3.
REQ-033 Writeback to reg 12 with counter 0 -> data written, counter 0, wb_underflow_err=1 until reset; writeback to addr 0 -> handshake completes, rf_write_enable stays 0.
REQ-034 Reset asserted mid-handshake with counters nonzero -> next cycle all outputs at REQ-026 values, no write issued.
